vedic_mul_seq: RTL and testbench
================================

# vedic_mul_seq

Sequential controller that computes an unsigned WIDTH x WIDTH product by time-sharing a single 2x2 vedic partial-product unit. Each cycle it steps through one operand digit pair and accumulates the shifted partial product. The block sits between a valid/ready request source and a valid/ready result sink. It is the area-lean alternative to a fully unrolled vedic array.

## Interface

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2. D = WIDTH/2 is the number of 2-bit digits.

Ports:
- clk  in  1  rising-edge clock; the block has one clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair a, b is valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  unsigned multiplicand.
- b  in  WIDTH  unsigned multiplier.
- out_valid  out  1  product is valid.
- out_ready  in  1  sink accepts the product.
- product  out  2*WIDTH  unsigned a*b.
- busy  out  1  high in RUN or DONE.

## Operation

- The state machine has three states: IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, latch a and b into internal registers, clear the accumulator, set digit indices i=0 and j=0, and go to RUN.
- RUN:
  - Each cycle, the internal 2x2 unit forms pp = a[2i+1:2i] * b[2j+1:2j]. This is an exact 4-bit product, so 3*3=9 (4'b1001).
  - The accumulator updates as acc <= acc + (pp << 2*(i+j)).
  - Index stepping: j increments each cycle. When j=D-1, j wraps to 0 and i increments.
  - In the cycle where i=D-1 and j=D-1, the final accumulate is performed and the state goes to DONE.
- DONE:
  - out_valid=1 and product=acc.
  - On out_ready, return to IDLE.
- Accumulator width is 2*WIDTH with no truncation. The final value equals the exact product, so no overflow can occur.
- product is a registered output and is held stable while out_valid=1.
- product keeps its last value in IDLE and RUN. It is updated only on entry to DONE.
- Operand inputs a and b are ignored outside the IDLE handshake cycle.

## Timing

- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0, busy = 0.
  - product = 0, acc = 0, i = 0, j = 0.
- Latency: if the input handshake occurs at edge E, RUN spans the D*D cycles after E. out_valid is first high in the cycle after edge E + D*D. For WIDTH=8 this is 16 cycles.
- Minimum issue interval is D*D + 2 cycles: the handshake cycle, D*D RUN cycles, and at least one DONE cycle. The result handshake and a new request cannot overlap.
- in_ready is 0 throughout RUN and DONE. An in_valid pulse during those states is ignored and is not queued.
- Backpressure: DONE persists indefinitely while out_ready=0. out_valid and product stay constant.
- out_ready asserted outside DONE has no effect.
- Reset mid-operation: rst=1 at any edge aborts the computation and returns to the reset values at that edge. No partial product is ever presented, and in_ready=1 in the following cycle.
- rst has priority over all handshakes in the same cycle.

## Test plan

- Reset and idle check, WIDTH=8: hold rst for 2 cycles. Require out_valid=0, in_ready=1, product=16'h0000, busy=0. With a=0x00 and b=0x00, require product=0x0000 with out_valid first high 16 cycles after acceptance.
- Max operands: a=0xFF, b=0xFF, out_ready=1. Require product=16'hFE01. Require out_valid high for exactly 1 cycle, then in_ready=1 on the next cycle.
- Digit exactness: a=0x03, b=0x03 gives 16'h0009. a=0x0F, b=0x03 gives 16'h002D. a=0xC0, b=0xC0 gives 16'h9000.
- Backpressure: a=0x12, b=0x34, with out_ready=0 for 5 cycles after out_valid rises. Require product=16'h03A8 stable and out_valid=1 throughout. After out_ready=1, require IDLE on the next cycle.
- Ignored request: a=0x05, b=0x07. Pulse in_valid with a=0xFF, b=0xFF at RUN cycle 4. Require product=16'h0023 and no second result.
- Reset mid-op: a=0xAA, b=0x55. Assert rst at RUN cycle 7. Require out_valid never rises and in_ready=1 the next cycle. A subsequent a=0x02, b=0x03 must give 16'h0006.

Source files
------------

// File: rtl/vedic_mul_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : vedic_mul_seq_if
// Purpose  : Request/result handshake bundle for the sequential vedic multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface vedic_mul_seq_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface
`default_nettype wire

// File: rtl/vedic_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : vedic_mul_seq
// Purpose  : WIDTH x WIDTH unsigned multiplier time-sharing one 2x2 vedic cell.
// Revision : 1.0 - initial release
// ============================================================================
module vedic_mul_seq #(
    parameter int WIDTH = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    vedic_mul_seq_if.slave    bus
);
    localparam int D  = WIDTH / 2;
    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam logic [IW-1:0] c_LAST = IW'(D - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_product;
    logic [IW-1:0]        r_i;
    logic [IW-1:0]        r_j;

    logic                 w_load;
    logic                 w_step;
    logic                 w_last;
    logic [1:0]           w_da;
    logic [1:0]           w_db;
    logic                 w_c1;
    logic [3:0]           w_pp;
    logic [IW+1:0]        w_sh;
    logic [2*WIDTH-1:0]   w_acc_next;

    // 2x2 vedic cell: vertical and crosswise terms, carry rippled into upper bits.
    assign w_da  = r_a[2*r_i +: 2];
    assign w_db  = r_b[2*r_j +: 2];
    assign w_c1  = w_da[1] & w_db[0] & w_da[0] & w_db[1];
    assign w_pp  = {w_da[1] & w_db[1] & w_c1,
                    (w_da[1] & w_db[1]) ^ w_c1,
                    (w_da[1] & w_db[0]) ^ (w_da[0] & w_db[1]),
                    w_da[0] & w_db[0]};

    assign w_sh       = ({2'b00, r_i} + {2'b00, r_j}) << 1;
    assign w_acc_next = r_acc + ((2*WIDTH)'(w_pp) << w_sh);
    assign w_last     = (r_i == c_LAST) && (r_j == c_LAST);

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_load       = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_i       <= '0;
            r_j       <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_a   <= bus.a;
                r_b   <= bus.b;
                r_acc <= '0;
                r_i   <= '0;
                r_j   <= '0;
            end
            if (w_step) begin
                r_acc <= w_acc_next;
                if (w_last) begin
                    r_i       <= '0;
                    r_j       <= '0;
                    r_product <= w_acc_next;
                end else if (r_j == c_LAST) begin
                    r_j <= '0;
                    r_i <= r_i + 1'b1;
                end else begin
                    r_j <= r_j + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.product   = r_product;
endmodule
`default_nettype wire

// File: tb/tb_vedic_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_vedic_mul_seq
// Purpose  : Directed self-checking bench for vedic_mul_seq at WIDTH=8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vedic_mul_seq;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    vedic_mul_seq_if #(.WIDTH(WIDTH)) bus ();

    vedic_mul_seq #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake one operand pair; returns after the accepting edge (+1).
    task automatic issue(input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.a        = 8'h00;
        bus.b        = 8'h00;
    endtask

    // Counts edges until out_valid, bounded.
    task automatic wait_result(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic [15:0] exp);
        int n;
        issue(av, bv);
        wait_result(n);
        check({tag, "_lat"}, 32'(n), 32'd16);
        check({tag, "_prod"}, 32'(bus.product), 32'(exp));
        tick();
        check({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int n;
        int seen;
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        bus.out_ready = 1'b1;

        tick();
        tick();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_product",   32'(bus.product),   32'h0000);
        check("rst_busy",      32'(bus.busy),      32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("zero", 8'h00, 8'h00, 16'h0000);

        // Max operands: single-cycle DONE with out_ready held high.
        issue(8'hFF, 8'hFF);
        check("max_busy", 32'(bus.busy), 32'd1);
        check("max_in_ready_run", 32'(bus.in_ready), 32'd0);
        wait_result(n);
        check("max_lat", 32'(n), 32'd16);
        check("max_prod", 32'(bus.product), 32'hFE01);
        tick();
        check("max_valid_once", 32'(bus.out_valid), 32'd0);
        check("max_in_ready", 32'(bus.in_ready), 32'd1);

        run_op("d33", 8'h03, 8'h03, 16'h0009);
        run_op("d0f3", 8'h0F, 8'h03, 16'h002D);
        run_op("dc0c0", 8'hC0, 8'hC0, 16'h9000);

        // Backpressure: result held for 5 cycles.
        bus.out_ready = 1'b0;
        issue(8'h12, 8'h34);
        wait_result(n);
        check("bp_lat", 32'(n), 32'd16);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_prod", 32'(bus.product), 32'h03A8);
            tick();
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        tick();
        check("bp_idle", 32'(bus.in_ready), 32'd1);
        check("bp_valid_drop", 32'(bus.out_valid), 32'd0);

        // Ignored request during RUN.
        issue(8'h05, 8'h07);
        tick();
        tick();
        tick();
        @(negedge clk);
        bus.a        = 8'hFF;
        bus.b        = 8'hFF;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.a        = 8'h00;
        bus.b        = 8'h00;
        wait_result(n);
        check("ign_lat", 32'(n + 4), 32'd16);
        check("ign_prod", 32'(bus.product), 32'h0023);
        tick();
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.out_valid === 1'b1 || bus.busy === 1'b1) seen++;
            tick();
        end
        check("ign_no_second", 32'(seen), 32'd0);

        // Reset mid-operation.
        issue(8'hAA, 8'h55);
        for (int k = 0; k < 6; k++) tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("mid_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_busy", 32'(bus.busy), 32'd0);
        check("mid_product", 32'(bus.product), 32'h0000);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.out_valid === 1'b1) seen++;
            tick();
        end
        check("mid_no_valid", 32'(seen), 32'd0);

        run_op("post", 8'h02, 8'h03, 16'h0006);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
